// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: one load or store per op over a req/ack bus,
// with load alignment/extension, misalignment detection and a bus timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_dmem_odata,
  output logic        mem_done,
  output logic        mem_stall,
  output logic        mem_addr_err,
  output logic        mem_bus_err,
  output logic [1:0]  dbg_state
);
  // Bus handshake: dmem_req and all request fields are held constant from the
  // first BUSY cycle until the cycle dmem_ack=1 (or the timeout), then req drops.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [1:0]       alo_q;
  logic             req_q, we_q, done_q, addr_err_q, bus_err_q;
  logic [31:0]      addr_q, wdata_q, odata_q;
  logic [3:0]       be_q;

  logic             misalign_d, is_store_d;
  logic [3:0]       be_d;
  logic [31:0]      wdata_d, load_d;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  always_comb begin
    misalign_d = 1'b0;
    is_store_d = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = mem_wdata;
    case (mem_op)
      OP_LW:         misalign_d = |mem_addr[1:0];
      OP_LH, OP_LHU: misalign_d = mem_addr[0];
      OP_SW: begin
        is_store_d = 1'b1;
        misalign_d = |mem_addr[1:0];
      end
      OP_SH: begin
        is_store_d = 1'b1;
        misalign_d = mem_addr[0];
        be_d       = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{mem_wdata[15:0]}};
      end
      OP_SB: begin
        is_store_d = 1'b1;
        be_d       = 4'b0001 << mem_addr[1:0];
        wdata_d    = {4{mem_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting uses the latched op and low address bits, never the live inputs.
  always_comb begin
    byte_sel = dmem_rdata[{alo_q, 3'b000} +: 8];
    half_sel = alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_d   = dmem_rdata;
    case (op_q)
      OP_LH:   load_d = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_d = {16'h0000, half_sel};
      OP_LB:   load_d = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_d = {24'h000000, byte_sel};
      default: load_d = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= 3'b000;
      alo_q      <= 2'b00;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      odata_q    <= 32'h0;
      be_q       <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          done_q     <= 1'b0;
          addr_err_q <= 1'b0;
          bus_err_q  <= 1'b0;
          if (mem_op_valid) begin
            if (misalign_d) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              addr_err_q <= 1'b1;
              odata_q    <= 32'h0;
            end else begin
              state_q <= BUSY;
              req_q   <= 1'b1;
              we_q    <= is_store_d;
              addr_q  <= {mem_addr[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              op_q    <= mem_op;
              alo_q   <= mem_addr[1:0];
              cnt_q   <= '0;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            if (!we_q) odata_q <= load_d;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            req_q     <= 1'b0;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            odata_q   <= 32'h0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          addr_err_q <= 1'b0;
          bus_err_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_stall      = ((state_q == IDLE) & mem_op_valid) | (state_q == BUSY);
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_be        = be_q;
  assign mem_dmem_odata = odata_q;
  assign mem_done       = done_q;
  assign mem_addr_err   = addr_err_q;
  assign mem_bus_err    = bus_err_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4): driver tasks push expected completions and
// bus requests into queues; a negedge monitor pops and compares them.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_op_valid;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_dmem_odata;
  logic [3:0]  dmem_be;
  logic        mem_done, mem_stall, mem_addr_err, mem_bus_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];  // {odata, addr_err, bus_err}
  logic [68:0] req_q[$];  // {we, addr, be, wdata}

  mem_access_unit #(.TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst_n),
    .mem_op_valid(mem_op_valid), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_dmem_odata(mem_dmem_odata), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_addr_err(mem_addr_err), .mem_bus_err(mem_bus_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 of the cycle after DONE.
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int ack_wait,
                       input logic [31:0] exp_odata, input logic exp_ae, input logic exp_berr,
                       input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_dw,
                       input int exp_done_cyc, input int exp_req_cyc);
    int cyc, req_cyc, busy;
    bit done_seen;
    if (!exp_ae) req_q.push_back({exp_we, addr[31:2], 2'b00, exp_be, exp_dw});
    exp_q.push_back({exp_odata, exp_ae, exp_berr});
    mem_op_valid = 1'b1;
    mem_op       = op;
    mem_addr     = addr;
    mem_wdata    = wdata;
    #1 chk("stall_cycle0", 32'(mem_stall), 32'd1);
    done_seen = 0; cyc = 0; req_cyc = 0; busy = 0;
    while (!done_seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_done) begin
        done_seen = 1;
        dmem_ack  = 1'b0;
        chk("stall_in_done", 32'(mem_stall), 32'd0);
        chk("req_in_done", 32'(dmem_req), 32'd0);
      end else if (dmem_req) begin
        req_cyc++;
        chk("stall_busy", 32'(mem_stall), 32'd1);
        dmem_ack   = (busy == ack_wait);
        dmem_rdata = rdata;
        busy++;
      end else begin
        dmem_ack = 1'b0;
      end
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout op=%0d addr=%h no mem_done in 20 cycles", op, addr);
    end
    chk("done_cycle", 32'(cyc), 32'(exp_done_cyc));
    chk("req_cycles", 32'(req_cyc), 32'(exp_req_cyc));
    @(posedge clk); #1;
    mem_op_valid = 1'b0;
  endtask

  // Monitor: compares every completion and every new bus request against the queues.
  initial begin
    logic        prev_req;
    logic [33:0] e;
    logic [68:0] r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done odata=%h", mem_dmem_odata);
        end else begin
          e = exp_q.pop_front();
          chk("odata", mem_dmem_odata, e[33:2]);
          chk("addr_err", 32'(mem_addr_err), 32'(e[1]));
          chk("bus_err", 32'(mem_bus_err), 32'(e[0]));
        end
      end else if (mem_addr_err || mem_bus_err) begin
        checks++; errors++;
        $display("FAIL err_outside_done addr_err=%b bus_err=%b exp=0", mem_addr_err, mem_bus_err);
      end
      if (dmem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req addr=%h", dmem_addr);
        end else begin
          r = req_q.pop_front();
          chk("req_we", 32'(dmem_we), 32'(r[68]));
          chk("req_addr", dmem_addr, r[67:36]);
          chk("req_be", 32'(dmem_be), 32'(r[35:32]));
          if (r[68]) chk("req_wdata", dmem_wdata, r[31:0]);
        end
      end
      prev_req = dmem_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_op_valid = 1'b0; mem_op = 3'b000; mem_addr = 32'h0;
    mem_wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_done", 32'(mem_done), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_odata", mem_dmem_odata, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads: op, addr, wdata, rdata, ack_wait, odata, ae, berr, we, be, dwdata, done_cyc, req_cyc
    do_op(3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'h0, 2, 1);
    do_op(3'b011, 32'h103, 32'h0, 32'h80112233, 0, 32'hFFFFFF80, 0, 0, 0, 4'b1111, 32'h0, 2, 1);
    do_op(3'b100, 32'h103, 32'h0, 32'h80112233, 1, 32'h00000080, 0, 0, 0, 4'b1111, 32'h0, 3, 2);
    do_op(3'b001, 32'h102, 32'h0, 32'h80112233, 0, 32'hFFFF8011, 0, 0, 0, 4'b1111, 32'h0, 2, 1);
    do_op(3'b010, 32'h100, 32'h0, 32'h80112233, 0, 32'h00002233, 0, 0, 0, 4'b1111, 32'h0, 2, 1);
    do_op(3'b011, 32'h101, 32'h0, 32'h80112233, 2, 32'h00000022, 0, 0, 0, 4'b1111, 32'h0, 4, 3);
    // Stores leave odata unchanged
    do_op(3'b111, 32'h201, 32'h000000AB, 32'h55555555, 0, 32'h00000022, 0, 0, 1, 4'b0010, 32'hABABABAB, 2, 1);
    do_op(3'b110, 32'h202, 32'h00001234, 32'h0, 0, 32'h00000022, 0, 0, 1, 4'b1100, 32'h12341234, 2, 1);
    do_op(3'b110, 32'h200, 32'hFFFF5678, 32'h0, 0, 32'h00000022, 0, 0, 1, 4'b0011, 32'h56785678, 2, 1);
    do_op(3'b101, 32'h300, 32'hCAFEF00D, 32'h0, 1, 32'h00000022, 0, 0, 1, 4'b1111, 32'hCAFEF00D, 3, 2);
    // Misaligned: no bus access, done next cycle
    do_op(3'b000, 32'h102, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0, 4'b0000, 32'h0, 1, 0);
    do_op(3'b110, 32'h301, 32'h1234, 32'h0, 0, 32'h0, 1, 0, 1, 4'b0000, 32'h0, 1, 0);
    do_op(3'b010, 32'h101, 32'h0, 32'h0, 0, 32'h0, 1, 0, 0, 4'b0000, 32'h0, 1, 0);
    // Ack on the last allowed BUSY cycle, then a full timeout
    do_op(3'b000, 32'h104, 32'h0, 32'h11223344, 3, 32'h11223344, 0, 0, 0, 4'b1111, 32'h0, 5, 4);
    do_op(3'b000, 32'h400, 32'h0, 32'h0, -1, 32'h0, 0, 1, 0, 4'b1111, 32'h0, 5, 4);

    // Reset in the middle of an access
    req_q.push_back({1'b0, 32'h600, 4'b1111, 32'h0});
    mem_op_valid = 1'b1; mem_op = 3'b000; mem_addr = 32'h600;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0; mem_op_valid = 1'b0;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_stall", 32'(mem_stall), 32'd0);
    chk("midrst_done", 32'(mem_done), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("late_ack_req", 32'(dmem_req), 32'd0);
      chk("late_ack_done", 32'(mem_done), 32'd0);
    end
    dmem_ack = 1'b0;
    chk("late_ack_odata", mem_dmem_odata, 32'h0);
    do_op(3'b000, 32'h500, 32'h0, 32'h0BADF00D, 1, 32'h0BADF00D, 0, 0, 0, 4'b1111, 32'h0, 3, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
